// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the EX-stage ALU.
//
// Decodes (alu_op, funct3, funct7b5) into the 4-bit ALU control code and
// selects/conditions the two ALU operands. Results are held in a two-entry
// buffer (main = output register, skid = second entry). This lets the stage
// sustain one operation per cycle while in_ready comes only from a flop.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   alu_op, funct3,
//   funct7b5            decoded instruction fields
//   rs1_data, rs2_data,
//   imm, use_imm        operand sources; use_imm selects imm as operand B
//   out_valid/out_ready downstream handshake
//   alu_control         4-bit ALU control code (1111 when illegal)
//   op_a, op_b          conditioned ALU operands
//   illegal             unsupported encoding flag
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            illegal
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SLTU = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SRL  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1001;
    localparam logic [3:0] CTRL_ILL  = 4'b1111;

    // Entry layout: {illegal, alu_control, op_a, op_b}
    localparam int EW = 1 + 4 + 2 * XLEN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Returns {illegal, control}; control is forced to 1111 when illegal.
    function automatic logic [4:0] decode_op(
        input logic [1:0] op,
        input logic [2:0] f3,
        input logic       b5
    );
        logic [3:0] ctrl;
        logic       ill;
        ctrl = CTRL_ADD;
        ill  = 1'b0;
        case (op)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b10, 2'b11: begin
                case (f3)
                    // I-type has no SUB: funct7b5 there is immediate bits.
                    3'b000:  ctrl = (b5 && (op == 2'b10)) ? CTRL_SUB : CTRL_ADD;
                    3'b001:  ctrl = CTRL_SLL;
                    3'b010:  ctrl = CTRL_SLT;
                    3'b011:  ctrl = CTRL_SLTU;
                    3'b100:  ctrl = CTRL_XOR;
                    3'b101:  ctrl = b5 ? CTRL_SRA : CTRL_SRL;
                    3'b110:  ctrl = CTRL_OR;
                    3'b111:  ctrl = CTRL_AND;
                    default: ctrl = CTRL_ADD;
                endcase
                // R-type: b5 only meaningful for 000/101. I-type: only
                // funct3 001 (SLLI) requires b5 clear.
                ill = (op == 2'b10) ? (b5 && (f3 != 3'b000) && (f3 != 3'b101))
                                    : (b5 && (f3 == 3'b001));
            end
            default: ctrl = CTRL_ADD;
        endcase
        ctrl = ill ? CTRL_ILL : ctrl;
        return {ill, ctrl};
    endfunction

    state_t          state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [4:0]      dec_s;
    logic [XLEN-1:0] opb_raw_s;
    logic [XLEN-1:0] new_a_s;
    logic [XLEN-1:0] new_b_s;
    logic [EW-1:0]   new_entry_s;
    logic            is_shift_s;
    logic            accept_s;
    logic            consume_s;

    // Decode the incoming operation and condition its operands.
    always_comb begin
        dec_s      = decode_op(alu_op, funct3, funct7b5);
        opb_raw_s  = use_imm ? imm : rs2_data;
        is_shift_s = (dec_s[3:0] == CTRL_SLL) || (dec_s[3:0] == CTRL_SRL) ||
                     (dec_s[3:0] == CTRL_SRA);
        if (dec_s[4]) begin
            new_a_s = {XLEN{1'b0}};
            new_b_s = {XLEN{1'b0}};
        end else if (is_shift_s) begin
            new_a_s = rs1_data;
            new_b_s = {{(XLEN-5){1'b0}}, opb_raw_s[4:0]};
        end else begin
            new_a_s = rs1_data;
            new_b_s = opb_raw_s;
        end
        new_entry_s = {dec_s, new_a_s, new_b_s};
    end

    // Buffer state machine: next state and entry movement.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        accept_s  = in_valid & in_ready_q;
        consume_s = out_valid_q & out_ready;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_d  = new_entry_s;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                case ({accept_s, consume_s})
                    2'b10: begin
                        skid_d  = new_entry_s;
                        state_d = ST_FULL;
                    end
                    2'b01:   state_d = ST_EMPTY;
                    2'b11:   main_d  = new_entry_s;
                    default: state_d = ST_ONE;
                endcase
            end
            ST_FULL: begin
                if (consume_s) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= {EW{1'b0}};
            skid_q      <= {EW{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign illegal     = main_q[EW-1];
    assign alu_control = main_q[EW-2:EW-5];
    assign op_a        = main_q[2*XLEN-1:XLEN];
    assign op_b        = main_q[XLEN-1:0];

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with hand-computed expected values.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic ui);
        alu_op = op; funct3 = f3; funct7b5 = b5;
        rs1_data = a; rs2_data = b; imm = im; use_imm = ui;
    endtask

    // Issue one op with out_ready=1 and check it one cycle later.
    task automatic do_one(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic b5, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic ui,
                          input logic [3:0] e_ctrl, input logic e_ill,
                          input logic [31:0] e_a, input logic [31:0] e_b);
        out_ready = 1'b1;
        set_op(op, f3, b5, a, b, im, ui);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".ctrl"}, {28'd0, alu_control}, {28'd0, e_ctrl});
        chk({tag, ".ill"}, {31'd0, illegal}, {31'd0, e_ill});
        chk({tag, ".opa"}, op_a, e_a);
        chk({tag, ".opb"}, op_b, e_b);
    endtask

    // Stream n ADD ops (rs1 = base+k); out_ready held low for the first hold cycles.
    task automatic stream(input string tag, input int n, input int hold, input logic [31:0] base);
        int  sent = 0;
        int  got = 0;
        int  cyc = 0;
        bit  acc;
        int  first_cyc;
        first_cyc = (hold == 0) ? 1 : hold;
        out_ready = (hold == 0);
        set_op(2'b00, 3'b000, 1'b0, base, 32'd0, 32'd0, 1'b0);
        in_valid = 1'b1;
        while (got < n && cyc < 60) begin
            if (out_valid && out_ready) begin
                chk({tag, ".seq"}, op_a, base + got);
                chk({tag, ".ctrl"}, {28'd0, alu_control}, 32'h2);
                chk({tag, ".lat"}, cyc, first_cyc + got);
                got++;
            end
            if (hold > 2 && cyc >= 2 && cyc < hold) begin
                chk({tag, ".bp_rdy"}, {31'd0, in_ready}, 32'd0);
                chk({tag, ".bp_hold"}, op_a, base);
                chk({tag, ".bp_acc"}, sent, 32'd2);
            end
            if (got < n) begin
                acc = in_valid && in_ready;
                tick();
                cyc++;
                if (acc) sent++;
                if (sent >= n) in_valid = 1'b0;
                else rs1_data = base + sent;
                out_ready = (cyc >= hold);
            end
        end
        chk({tag, ".count"}, got, n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    logic [3:0] r_ctrl [16];
    initial begin
        // index = {b5, funct3}
        r_ctrl = '{4'h2, 4'h5, 4'h7, 4'h3, 4'h4, 4'h8, 4'h1, 4'h0,
                   4'h6, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'hF, 4'hF};
    end

    initial begin
        logic ill;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        set_op(2'b10, 3'b000, 1'b0, 32'h5, 32'h6, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.ctrl", {28'd0, alu_control}, 32'd0);
        chk("rst.opa", op_a, 32'd0);
        chk("rst.opb", op_b, 32'd0);
        chk("rst.ill", {31'd0, illegal}, 32'd0);

        // R-type sweep
        for (int i = 0; i < 16; i++) begin
            ill = (r_ctrl[i] == 4'hF);
            do_one($sformatf("r%0d", i), 2'b10, i[2:0], i[3], 32'h10, 32'h3, 32'h0, 1'b0,
                   r_ctrl[i], ill, ill ? 32'h0 : 32'h10, ill ? 32'h0 : 32'h3);
        end

        // I-type
        do_one("i_srai", 2'b11, 3'b101, 1'b1, 32'h80, 32'h1234, 32'hFFFF_FFE5, 1'b1,
               4'h9, 1'b0, 32'h80, 32'h5);
        do_one("i_addi", 2'b11, 3'b000, 1'b1, 32'h80, 32'h1234, 32'hFFFF_FFE5, 1'b1,
               4'h2, 1'b0, 32'h80, 32'hFFFF_FFE5);
        do_one("i_slli_bad", 2'b11, 3'b001, 1'b1, 32'h80, 32'h1234, 32'hFFFF_FFE5, 1'b1,
               4'hF, 1'b1, 32'h0, 32'h0);
        do_one("i_slli", 2'b11, 3'b001, 1'b0, 32'h80, 32'h1234, 32'hFFFF_FFE5, 1'b1,
               4'h5, 1'b0, 32'h80, 32'h5);
        do_one("i_slti", 2'b11, 3'b010, 1'b1, 32'h80, 32'h1234, 32'hFFFF_FFE5, 1'b1,
               4'h7, 1'b0, 32'h80, 32'hFFFF_FFE5);
        do_one("r_sll_big", 2'b10, 3'b001, 1'b0, 32'h1, 32'hFFFF_FF23, 32'h0, 1'b0,
               4'h5, 1'b0, 32'h1, 32'h3);

        // Classes 00 / 01
        do_one("c00", 2'b00, 3'b111, 1'b1, 32'hA, 32'hB, 32'hC, 1'b0,
               4'h2, 1'b0, 32'hA, 32'hB);
        do_one("c01", 2'b01, 3'b101, 1'b1, 32'hA, 32'hB, 32'hC, 1'b1,
               4'h6, 1'b0, 32'hA, 32'hC);

        // drain to EMPTY
        out_ready = 1'b1;
        tick();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure then release
        stream("bp", 5, 5, 32'h100);
        // Streaming
        stream("st", 8, 0, 32'h200);

        // Reset with FULL occupied
        out_ready = 1'b0;
        set_op(2'b10, 3'b100, 1'b0, 32'h33, 32'h44, 32'h0, 1'b0);
        in_valid = 1'b1;
        tick();
        tick();
        chk("full.ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.ready", {31'd0, in_ready}, 32'd1);
        chk("mrst.ctrl", {28'd0, alu_control}, 32'd0);
        chk("mrst.opa", op_a, 32'd0);
        chk("mrst.opb", op_b, 32'd0);
        chk("mrst.ill", {31'd0, illegal}, 32'd0);
        tick();
        chk("mrst.idle", {31'd0, out_valid}, 32'd0);
        stream("post", 1, 0, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
